// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions
// and the hex-to-segment table (active-high, bit order {g,f,e,d,c,b,a}).
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational nibble decoder producing the active-high {g..a} pattern.
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  logic [6:0] pat_s;

  // Table lookup, repacked through the named bit positions
  always_comb begin
    pat_s = HEX_SEG[nibble];
    segs  = {pat_s[SEG_G], pat_s[SEG_F], pat_s[SEG_E], pat_s[SEG_D],
             pat_s[SEG_C], pat_s[SEG_B], pat_s[SEG_A]};
  end

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed seven-segment driver: shadowed digit data, prescaled digit
// scan, PWM brightness and registered, polarity-selectable outputs.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int NDIGITS    = 4,
  parameter int PRESC_W    = 10,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk50,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  input  logic                   load,
  input  logic [2:0]             bright,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             seg,
  output logic                   dpo,
  output logic                   scan_tick
);

  localparam int                 IW         = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0]      IDX_LAST   = IW'(NDIGITS - 1);
  localparam logic [IW-1:0]      IDX_ONE    = IW'(1);
  localparam logic [PRESC_W-1:0] PRESC_MAX  = {PRESC_W{1'b1}};
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic               POL        = (ACTIVE_LOW != 0);

  logic [PRESC_W-1:0]   presc_r;
  logic [IW-1:0]        idx_r;
  logic [4*NDIGITS-1:0] val_r;
  logic [NDIGITS-1:0]   dp_r;
  logic [NDIGITS-1:0]   blank_r;
  logic                 tick_r;
  logic [NDIGITS-1:0]   an_r;
  logic [6:0]           seg_r;
  logic                 dpo_r;

  logic                 wrap_s;
  logic [3:0]           nib_s;
  logic                 dp_sel_s;
  logic                 blank_sel_s;
  logic                 lit_s;
  logic [6:0]           seg_dec_s;
  logic [NDIGITS-1:0]   an_hi_s;
  logic [6:0]           seg_hi_s;
  logic                 dpo_hi_s;

  seg7_hexdec u_hexdec (
    .nibble (nib_s),
    .segs   (seg_dec_s)
  );

  // Select the current digit's shadow data and decide whether it is lit
  always_comb begin
    wrap_s      = (presc_r == PRESC_MAX);
    nib_s       = val_r[{idx_r, 2'b00} +: 4];
    dp_sel_s    = dp_r[idx_r];
    blank_sel_s = blank_r[idx_r];
    // Prescaler 0 is always dark so the digit switch never overlaps segment data
    if (!blank_sel_s && (presc_r != PRESC_ZERO) && (presc_r[PRESC_W-1 -: 3] <= bright)) begin
      lit_s = 1'b1;
    end else begin
      lit_s = 1'b0;
    end
    for (int k = 0; k < NDIGITS; k++) begin
      an_hi_s[k] = lit_s && (idx_r == k[IW-1:0]);
    end
    seg_hi_s = lit_s ? seg_dec_s : 7'b0000000;
    dpo_hi_s = lit_s & dp_sel_s;
  end

  // Prescaler, digit index and scan tick
  always_ff @(posedge clk50) begin
    if (reset) begin
      presc_r <= PRESC_ZERO;
      idx_r   <= {IW{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
      tick_r  <= wrap_s;
      if (wrap_s) begin
        idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IDX_ONE;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Shadow registers: the display only ever reads these
  always_ff @(posedge clk50) begin
    if (reset) begin
      val_r   <= {(4*NDIGITS){1'b0}};
      dp_r    <= {NDIGITS{1'b0}};
      blank_r <= {NDIGITS{1'b1}};
    end else if (load) begin
      val_r   <= value;
      dp_r    <= dp;
      blank_r <= blank;
    end else begin
      val_r   <= val_r;
      dp_r    <= dp_r;
      blank_r <= blank_r;
    end
  end

  // Output registers with polarity applied
  always_ff @(posedge clk50) begin
    if (reset) begin
      an_r  <= {NDIGITS{POL}};
      seg_r <= {7{POL}};
      dpo_r <= POL;
    end else begin
      an_r  <= an_hi_s ^ {NDIGITS{POL}};
      seg_r <= seg_hi_s ^ {7{POL}};
      dpo_r <= dpo_hi_s ^ POL;
    end
  end

  assign an        = an_r;
  assign seg       = seg_r;
  assign dpo       = dpo_r;
  assign scan_tick = tick_r;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed, table-driven bench for seg7_scanner (3 digits, 16-clock slots),
// with a second active-low instance sharing the same stimulus.
module tb_seg7_scanner;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [11:0] value = 12'h000;
  logic [2:0]  dp    = 3'b000;
  logic [2:0]  blank = 3'b000;
  logic [2:0]  bright = 3'b000;

  logic [2:0] an, an_l;
  logic [6:0] seg, seg_l;
  logic       dpo, dpo_l, scan_tick, tick_l;

  seg7_scanner #(.NDIGITS(3), .PRESC_W(4), .ACTIVE_LOW(0)) dut (
    .clk50(clk50), .reset(reset), .value(value), .dp(dp), .blank(blank),
    .load(load), .bright(bright), .an(an), .seg(seg), .dpo(dpo), .scan_tick(scan_tick)
  );

  seg7_scanner #(.NDIGITS(3), .PRESC_W(4), .ACTIVE_LOW(1)) dut_al (
    .clk50(clk50), .reset(reset), .value(value), .dp(dp), .blank(blank),
    .load(load), .bright(bright), .an(an_l), .seg(seg_l), .dpo(dpo_l), .scan_tick(tick_l)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    int         cyc;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dpo;
    logic       tick;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0, n_bad = 0, n = 0;
  int lit_cnt, tick_cnt, an1_cnt, dpo_bad, mix_bad;
  int br_cyc, ld_cyc;
  logic [2:0]  br_new;
  logic [11:0] ld_val;
  bit chk_mix;

  function automatic vec_t mk(input int c, input logic [2:0] a, input logic [6:0] s,
                              input logic d, input logic t);
    vec_t r;
    r.cyc = c; r.an = a; r.seg = s; r.dpo = d; r.tick = t;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
    n++;
  endtask

  // Reset, then release with a load of the given shadow data; n counts edges since release
  task automatic start(input logic [11:0] v, input logic [2:0] d, input logic [2:0] b,
                       input logic [2:0] br);
    reset = 1'b1; load = 1'b0;
    br_cyc = -1; ld_cyc = -1; chk_mix = 1'b0;
    tbl.delete();
    repeat (2) @(posedge clk50);
    #1;
    reset = 1'b0; load = 1'b1; value = v; dp = d; blank = b; bright = br;
    n = 0; lit_cnt = 0; tick_cnt = 0; an1_cnt = 0; dpo_bad = 0; mix_bad = 0;
    step();
    load = 1'b0;
  endtask

  task automatic run(input int last);
    while (n < last) begin
      step();
      if (an != 3'b000) lit_cnt++;
      if (scan_tick) tick_cnt++;
      if (an[1]) an1_cnt++;
      if (dpo !== an[0]) dpo_bad++;
      if (chk_mix && an != 3'b000 && seg !== ((n <= 16) ? 7'b0111111 : 7'b1110001)) mix_bad++;
      foreach (tbl[i]) begin
        if (tbl[i].cyc == n) begin
          chk($sformatf("an@%0d", n),   32'(an),        32'(tbl[i].an));
          chk($sformatf("seg@%0d", n),  32'(seg),       32'(tbl[i].seg));
          chk($sformatf("dpo@%0d", n),  32'(dpo),       32'(tbl[i].dpo));
          chk($sformatf("tick@%0d", n), 32'(scan_tick), 32'(tbl[i].tick));
        end
      end
      if (n == br_cyc) bright = br_new;
      if (n == ld_cyc) begin
        load = 1'b1; value = ld_val;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    int first_tick, residual;

    // Reset state, both polarities
    repeat (2) @(posedge clk50);
    #1;
    chk("rst_an",   32'(an),        32'(3'b000));
    chk("rst_seg",  32'(seg),       32'(7'b0000000));
    chk("rst_dpo",  32'(dpo),       32'(1'b0));
    chk("rst_tick", 32'(scan_tick), 32'(1'b0));
    chk("rst_an_l",  32'(an_l),   32'(3'b111));
    chk("rst_seg_l", 32'(seg_l),  32'(7'b1111111));
    chk("rst_dpo_l", 32'(dpo_l),  32'(1'b1));
    chk("rst_tick_l", 32'(tick_l), 32'(1'b0));

    // Full brightness scan of 5A0
    start(12'h5A0, 3'b000, 3'b000, 3'd7);
    chk("p1_an@1", 32'(an), 32'(3'b000));
    tbl.push_back(mk(2,  3'b001, 7'b0111111, 1'b0, 1'b0));
    tbl.push_back(mk(16, 3'b001, 7'b0111111, 1'b0, 1'b1));
    tbl.push_back(mk(17, 3'b000, 7'b0000000, 1'b0, 1'b0));
    tbl.push_back(mk(18, 3'b010, 7'b1110111, 1'b0, 1'b0));
    tbl.push_back(mk(32, 3'b010, 7'b1110111, 1'b0, 1'b1));
    tbl.push_back(mk(34, 3'b100, 7'b1101101, 1'b0, 1'b0));
    tbl.push_back(mk(50, 3'b001, 7'b0111111, 1'b0, 1'b0));
    run(50);
    chk("p1_lit_cnt",  32'(lit_cnt),  32'(46));
    chk("p1_tick_cnt", 32'(tick_cnt), 32'(3));

    // Minimum brightness, then bright=3 from cycle 48 onward
    start(12'h5A0, 3'b000, 3'b000, 3'd0);
    br_cyc = 48; br_new = 3'd3;
    tbl.push_back(mk(2,  3'b001, 7'b0111111, 1'b0, 1'b0));
    tbl.push_back(mk(3,  3'b000, 7'b0000000, 1'b0, 1'b0));
    tbl.push_back(mk(18, 3'b010, 7'b1110111, 1'b0, 1'b0));
    tbl.push_back(mk(19, 3'b000, 7'b0000000, 1'b0, 1'b0));
    tbl.push_back(mk(34, 3'b100, 7'b1101101, 1'b0, 1'b0));
    tbl.push_back(mk(49, 3'b000, 7'b0000000, 1'b0, 1'b0));
    tbl.push_back(mk(50, 3'b001, 7'b0111111, 1'b0, 1'b0));
    tbl.push_back(mk(56, 3'b001, 7'b0111111, 1'b0, 1'b0));
    tbl.push_back(mk(57, 3'b000, 7'b0000000, 1'b0, 1'b0));
    run(60);
    chk("p2_lit_cnt", 32'(lit_cnt), 32'(10));

    // Blank digit 1, decimal point on digit 0
    start(12'h5A0, 3'b001, 3'b010, 3'd7);
    tbl.push_back(mk(2,  3'b001, 7'b0111111, 1'b1, 1'b0));
    tbl.push_back(mk(18, 3'b000, 7'b0000000, 1'b0, 1'b0));
    tbl.push_back(mk(34, 3'b100, 7'b1101101, 1'b0, 1'b0));
    run(50);
    chk("p3_an1_cnt",  32'(an1_cnt), 32'(0));
    chk("p3_dpo_bad",  32'(dpo_bad), 32'(0));
    chk("p3_lit_cnt",  32'(lit_cnt), 32'(31));

    // Load FFF on the wrap edge: no mixed data
    start(12'h000, 3'b000, 3'b000, 3'd7);
    ld_cyc = 15; ld_val = 12'hFFF; chk_mix = 1'b1;
    tbl.push_back(mk(16, 3'b001, 7'b0111111, 1'b0, 1'b1));
    tbl.push_back(mk(17, 3'b000, 7'b0000000, 1'b0, 1'b0));
    tbl.push_back(mk(18, 3'b010, 7'b1110001, 1'b0, 1'b0));
    tbl.push_back(mk(34, 3'b100, 7'b1110001, 1'b0, 1'b0));
    run(40);
    chk("p4_mix_bad", 32'(mix_bad), 32'(0));

    // Reset mid-slot with a simultaneous load, then tick timing after release
    start(12'h5A0, 3'b000, 3'b000, 3'd7);
    run(20);
    chk("p5_an_pre", 32'(an), 32'(3'b010));
    load = 1'b1; value = 12'hFFF; blank = 3'b000; reset = 1'b1;
    step();
    chk("p5_an_rst",   32'(an),        32'(3'b000));
    chk("p5_seg_rst",  32'(seg),       32'(7'b0000000));
    chk("p5_tick_rst", 32'(scan_tick), 32'(1'b0));
    reset = 1'b0; load = 1'b0;
    first_tick = -1; residual = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (an != 3'b000) residual++;
      if (scan_tick) begin
        first_tick = k;
        break;
      end
    end
    chk("p5_first_tick", 32'(first_tick), 32'(16));
    chk("p5_residual",   32'(residual),   32'(0));

    // Active-low rendering of digit 8
    start(12'h008, 3'b000, 3'b000, 3'd7);
    step();
    chk("p6_an_l",  32'(an_l),  32'(3'b110));
    chk("p6_seg_l", 32'(seg_l), 32'(7'b0000000));
    chk("p6_dpo_l", 32'(dpo_l), 32'(1'b1));
    chk("p6_an",    32'(an),    32'(3'b001));
    chk("p6_seg",   32'(seg),   32'(7'b1111111));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
